// File: rtl/mem_ctrl_seq_pkg.sv
// rtl/mem_ctrl_seq_pkg.sv - register map, bit positions and sequencer state type
package mem_ctrl_seq_pkg;

    // Channel c occupies bytes [c*CH_STRIDE, c*CH_STRIDE + 0xF]
    localparam logic [7:0] CH_STRIDE  = 8'h10;
    localparam logic [7:0] ID_ADDR    = 8'hF0;

    // Byte offsets inside a channel window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CFG    = 4'h8;
    localparam logic [3:0] OFF_ERROR  = 4'hC;

    // CTRL bits
    localparam int CTRL_START     = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int CTRL_ABORT     = 5;
    localparam int MODE_W         = 4;

    // STATUS bits
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;

    // CFG layout: burst length at [BLEN_W-1:0], latency from this bit up
    localparam int CFG_LAT_LSB    = 8;

    // ERROR bits
    localparam int ERR_ZERO_LEN   = 0;
    localparam int ERR_BUSY_START = 1;
    localparam int ERR_ABORT      = 2;
    localparam int ERR_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LAT = 2'd1,
        ST_BURST    = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mem_ctrl_seq_if.sv
// rtl/mem_ctrl_seq_if.sv - CSR port and per-channel memory beat handshake bundle
// master: CSR host / memory datapath side; slave: the controller.
interface mem_ctrl_seq_if #(
    parameter int NUM_CH = 2
);
    logic                  csr_wr_en;
    logic                  csr_rd_en;
    logic [7:0]            csr_addr;
    logic [31:0]           csr_wr_data;
    logic [31:0]           csr_rd_data;
    logic                  csr_rd_valid;
    logic [NUM_CH-1:0]     mem_start;
    logic [4*NUM_CH-1:0]   mem_mode;
    logic [NUM_CH-1:0]     mem_beat_valid;
    logic [NUM_CH-1:0]     mem_beat_ready;
    logic [NUM_CH-1:0]     mem_beat_last;
    logic [NUM_CH-1:0]     mem_busy;
    logic                  error_flag;

    modport master (
        output csr_wr_en, csr_rd_en, csr_addr, csr_wr_data, mem_beat_ready,
        input  csr_rd_data, csr_rd_valid, mem_start, mem_mode, mem_beat_valid,
        input  mem_beat_last, mem_busy, error_flag
    );

    modport slave (
        input  csr_wr_en, csr_rd_en, csr_addr, csr_wr_data, mem_beat_ready,
        output csr_rd_data, csr_rd_valid, mem_start, mem_mode, mem_beat_valid,
        output mem_beat_last, mem_busy, error_flag
    );
endinterface

// File: rtl/mem_burst_channel.sv
// rtl/mem_burst_channel.sv - one channel: CTRL/STATUS/CFG/ERROR registers and burst FSM
// Ports: clk/rst_n; wr_en (write aimed at this channel), reg_sel (addr[3:2]), wr_data;
// beat_ready in; start/mode/beat_valid/beat_last/busy out; rd_word (selected register),
// err_any (OR of ERROR bits).
module mem_burst_channel
    import mem_ctrl_seq_pkg::*;
#(
    parameter int BLEN_W = 8,
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        reg_sel,
    input  logic [31:0]       wr_data,
    input  logic              beat_ready,
    output logic              start,
    output logic [MODE_W-1:0] mode,
    output logic              beat_valid,
    output logic              beat_last,
    output logic              busy,
    output logic [31:0]       rd_word,
    output logic              err_any
);
    seq_state_e         state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d, cnt_q, cnt_d;
    logic [BLEN_W-1:0]  len_q, len_d, rem_q, rem_d;
    logic [MODE_W-1:0]  mode_q, mode_d, snap_mode_q, snap_mode_d;
    logic               done_q, done_d, start_q, start_d;
    logic [ERR_W-1:0]   err_q, err_d, err_set;
    logic               done_set;

    logic ctrl_wr, status_wr, cfg_wr, error_wr, go, abort;
    assign ctrl_wr   = wr_en && (reg_sel == OFF_CTRL[3:2]);
    assign status_wr = wr_en && (reg_sel == OFF_STATUS[3:2]);
    assign cfg_wr    = wr_en && (reg_sel == OFF_CFG[3:2]);
    assign error_wr  = wr_en && (reg_sel == OFF_ERROR[3:2]);
    assign go        = ctrl_wr && wr_data[CTRL_START];
    assign abort     = ctrl_wr && wr_data[CTRL_ABORT];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        snap_mode_d = snap_mode_q;
        start_d     = 1'b0;
        err_set     = '0;
        done_set    = 1'b0;
        len_d       = cfg_wr  ? wr_data[BLEN_W-1:0] : len_q;
        lat_d       = cfg_wr  ? wr_data[CFG_LAT_LSB +: LAT_W] : lat_q;
        mode_d      = ctrl_wr ? wr_data[CTRL_MODE_LSB +: MODE_W] : mode_q;

        case (state_q)
            ST_IDLE: begin
                if (go && !abort) begin
                    if (len_q == '0) begin
                        err_set[ERR_ZERO_LEN] = 1'b1;
                    end else begin
                        // Mode comes from the same CTRL write that carries start
                        snap_mode_d = wr_data[CTRL_MODE_LSB +: MODE_W];
                        rem_d       = len_q;
                        start_d     = 1'b1;
                        if (lat_q == '0) begin
                            state_d = ST_BURST;
                        end else begin
                            state_d = ST_WAIT_LAT;
                            cnt_d   = lat_q;
                        end
                    end
                end
            end
            ST_WAIT_LAT: begin
                // Count of 1 is the final wait cycle, so latency L gives L wait cycles
                if (cnt_q == LAT_W'(1)) state_d = ST_BURST;
                else                    cnt_d   = cnt_q - LAT_W'(1);
            end
            ST_BURST: begin
                if (beat_ready) begin
                    rem_d = rem_q - BLEN_W'(1);
                    if (rem_q == BLEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                done_set = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start in the same write
        if (state_q != ST_IDLE) begin
            if (abort) begin
                state_d             = ST_IDLE;
                err_set[ERR_ABORT]  = 1'b1;
                done_set            = 1'b0;
            end else if (go) begin
                err_set[ERR_BUSY_START] = 1'b1;
            end
        end

        // W1C clear first, hardware set last so set wins on a collision
        done_d = (done_q & ~(status_wr & wr_data[STATUS_DONE])) | done_set;
        err_d  = (err_q & ~(error_wr ? wr_data[ERR_W-1:0] : '0)) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            snap_mode_q <= '0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            snap_mode_q <= snap_mode_d;
            done_q      <= done_d;
            start_q     <= start_d;
            err_q       <= err_d;
        end
    end

    assign start      = start_q;
    assign mode       = snap_mode_q;
    assign beat_valid = (state_q == ST_BURST);
    assign beat_last  = beat_valid && (rem_q == BLEN_W'(1));
    assign busy       = (state_q != ST_IDLE);
    assign err_any    = |err_q;

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            OFF_CTRL[3:2]:   rd_word[CTRL_MODE_LSB +: MODE_W] = mode_q;
            OFF_STATUS[3:2]: begin
                rd_word[STATUS_BUSY] = busy;
                rd_word[STATUS_DONE] = done_q;
            end
            OFF_CFG[3:2]: begin
                rd_word[BLEN_W-1:0]              = len_q;
                rd_word[CFG_LAT_LSB +: LAT_W]    = lat_q;
            end
            default:         rd_word[ERR_W-1:0] = err_q;
        endcase
    end

endmodule

// File: rtl/mem_ctrl_seq.sv
// rtl/mem_ctrl_seq.sv - multi-channel burst sequencer: CSR decode, read mux, error OR
// Ports: clk, rst_n (async active-low), bus (mem_ctrl_seq_if.slave: CSR port plus
// per-channel mem_start/mem_mode/mem_beat_* /mem_busy and error_flag).
module mem_ctrl_seq
    import mem_ctrl_seq_pkg::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          BLEN_W   = 8,
    parameter int          LAT_W    = 4,
    parameter logic [31:0] ID_VALUE = 32'h1234_AB02
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_ctrl_seq_if.slave bus
);
    logic              ch_space;
    logic [31:0]       ch_rd [NUM_CH];
    logic [NUM_CH-1:0] ch_err;
    logic [31:0]       rd_mux;
    logic [31:0]       csr_rd_data_q, csr_rd_data_d;
    logic              csr_rd_valid_q, csr_rd_valid_d;
    logic              error_flag_q, error_flag_d;

    // Word-aligned address inside an implemented channel window
    assign ch_space = (32'(bus.csr_addr[7:4]) < 32'(NUM_CH)) && (bus.csr_addr[1:0] == 2'b00);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_sel;
        assign ch_sel = ch_space && (bus.csr_addr[7:4] == 4'(c));

        mem_burst_channel #(
            .BLEN_W (BLEN_W),
            .LAT_W  (LAT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (bus.csr_wr_en && ch_sel),
            .reg_sel    (bus.csr_addr[3:2]),
            .wr_data    (bus.csr_wr_data),
            .beat_ready (bus.mem_beat_ready[c]),
            .start      (bus.mem_start[c]),
            .mode       (bus.mem_mode[c*MODE_W +: MODE_W]),
            .beat_valid (bus.mem_beat_valid[c]),
            .beat_last  (bus.mem_beat_last[c]),
            .busy       (bus.mem_busy[c]),
            .rd_word    (ch_rd[c]),
            .err_any    (ch_err[c])
        );
    end

    // Read mux samples pre-write register values, so a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        if (bus.csr_addr == ID_ADDR) rd_mux = ID_VALUE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_space && (bus.csr_addr[7:4] == 4'(c))) rd_mux = ch_rd[c];
        end
        csr_rd_data_d  = bus.csr_rd_en ? rd_mux : csr_rd_data_q;
        csr_rd_valid_d = bus.csr_rd_en;
        error_flag_d   = |ch_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rd_data_q  <= '0;
            csr_rd_valid_q <= 1'b0;
            error_flag_q   <= 1'b0;
        end else begin
            csr_rd_data_q  <= csr_rd_data_d;
            csr_rd_valid_q <= csr_rd_valid_d;
            error_flag_q   <= error_flag_d;
        end
    end

    assign bus.csr_rd_data  = csr_rd_data_q;
    assign bus.csr_rd_valid = csr_rd_valid_q;
    assign bus.error_flag   = error_flag_q;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb/tb_mem_ctrl_seq.sv - directed self-checking bench for mem_ctrl_seq
module tb_mem_ctrl_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mem_ctrl_seq_if #(.NUM_CH(2)) bus_if ();

    mem_ctrl_seq #(
        .NUM_CH   (2),
        .BLEN_W   (8),
        .LAT_W    (4),
        .ID_VALUE (32'h1234_AB02)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; write is captured at the next posedge, returns at the following negedge
    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.csr_wr_en   = 1'b1;
        bus_if.csr_addr    = a;
        bus_if.csr_wr_data = d;
        @(negedge clk);
        bus_if.csr_wr_en   = 1'b0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] d, output logic v);
        bus_if.csr_rd_en = 1'b1;
        bus_if.csr_addr  = a;
        @(negedge clk);
        bus_if.csr_rd_en = 1'b0;
        d = bus_if.csr_rd_data;
        v = bus_if.csr_rd_valid;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst_n = 1'b0;
        bus_if.csr_wr_en = 1'b0; bus_if.csr_rd_en = 1'b0;
        bus_if.csr_addr = '0; bus_if.csr_wr_data = '0; bus_if.mem_beat_ready = 2'b11;
        repeat (3) @(negedge clk);
        obs = {bus_if.mem_start, bus_if.mem_beat_valid, bus_if.mem_beat_last,
               bus_if.mem_busy, bus_if.error_flag, bus_if.csr_rd_valid};
        n_checks++;
        if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_ctl: got %h expected 0", obs); end
        n_checks++;
        if ({bus_if.mem_mode, bus_if.csr_rd_data} !== 40'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus_if.mem_mode, bus_if.csr_rd_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_burst();
        logic [3:0] obs, exp_v;
        logic [31:0] d; logic v;
        csr_write(8'h08, 32'h0000_0304);
        csr_write(8'h00, 32'h0000_0003);
        n_checks++;
        if (bus_if.mem_mode[3:0] !== 4'h1) begin n_fail++; $display("FAIL basic_mode: got %h expected 1", bus_if.mem_mode[3:0]); end
        // Cycle c after the start edge: {start, valid, last, busy}
        for (int c = 1; c <= 10; c++) begin
            exp_v = {c == 1, (c >= 4) && (c <= 7), c == 7, c <= 8};
            obs   = {bus_if.mem_start[0], bus_if.mem_beat_valid[0], bus_if.mem_beat_last[0], bus_if.mem_busy[0]};
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL basic_cycle%0d: got %b expected %b", c, obs, exp_v); end
            @(negedge clk);
        end
        csr_read(8'h04, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'h2}) begin n_fail++; $display("FAIL basic_status: got %b/%h expected 1/2", v, d); end
        n_checks++;
        if (bus_if.error_flag !== 1'b0) begin n_fail++; $display("FAIL basic_errflag: got %b expected 0", bus_if.error_flag); end
    endtask

    task automatic test_backpressure();
        logic [4:0] pat;
        int acc;
        pat = 5'b10101;
        acc = 0;
        csr_write(8'h18, 32'h0000_0003);
        csr_write(8'h10, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            bus_if.mem_beat_ready[1] = pat[i];
            n_checks++;
            if (bus_if.mem_beat_valid[1] !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b expected 1", i, bus_if.mem_beat_valid[1]); end
            n_checks++;
            if (bus_if.mem_beat_last[1] !== (acc == 2)) begin
                n_fail++; $display("FAIL bp_last%0d: got %b expected %b", i, bus_if.mem_beat_last[1], acc == 2);
            end
            if (pat[i]) acc++;
            @(negedge clk);
        end
        bus_if.mem_beat_ready[1] = 1'b1;
        n_checks++;
        if (acc !== 3 || bus_if.mem_beat_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL bp_end: got acc %0d valid %b expected 3/0", acc, bus_if.mem_beat_valid[1]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic v;
        logic [1:0] obs, exp_v;
        // Zero-length start
        csr_write(8'h08, 32'h0);
        csr_write(8'h00, 32'h1);
        n_checks++;
        if ({bus_if.mem_start[0], bus_if.mem_busy[0]} !== 2'b00) begin
            n_fail++; $display("FAIL zlen_start: got %b expected 00", {bus_if.mem_start[0], bus_if.mem_busy[0]});
        end
        csr_read(8'h0C, d, v);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL zlen_err: got %h expected 1", d); end
        n_checks++;
        if (bus_if.error_flag !== 1'b1) begin n_fail++; $display("FAIL zlen_flag: got %b expected 1", bus_if.error_flag); end
        // Start while busy on CH1: len 2, lat 5, second start one cycle later
        csr_write(8'h18, 32'h0000_0502);
        csr_write(8'h10, 32'h1);
        csr_write(8'h10, 32'h1);
        for (int c = 2; c <= 9; c++) begin
            exp_v = {(c == 6) || (c == 7), c <= 8};
            obs   = {bus_if.mem_beat_valid[1], bus_if.mem_busy[1]};
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL busy_start_cycle%0d: got %b expected %b", c, obs, exp_v); end
            @(negedge clk);
        end
        csr_read(8'h1C, d, v);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL busy_start_err: got %h expected 2", d); end
        csr_read(8'h14, d, v);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL busy_start_done: got %h expected 2", d); end
        // W1C clear of both channels
        csr_write(8'h0C, 32'h3);
        csr_write(8'h1C, 32'h3);
        csr_read(8'h0C, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_ch0: got %h expected 0", d); end
        csr_read(8'h1C, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_ch1: got %h expected 0", d); end
        n_checks++;
        if (bus_if.error_flag !== 1'b0) begin n_fail++; $display("FAIL w1c_flag: got %b expected 0", bus_if.error_flag); end
    endtask

    task automatic test_abort();
        logic [31:0] d; logic v;
        csr_write(8'h04, 32'h2);
        csr_read(8'h04, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL done_w1c: got %h expected 0", d); end
        csr_write(8'h08, 32'h0000_0008);
        csr_write(8'h00, 32'h1);
        @(negedge clk);
        n_checks++;
        if (bus_if.mem_beat_valid[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got %b expected 1", bus_if.mem_beat_valid[0]); end
        csr_write(8'h00, 32'h20);
        n_checks++;
        if ({bus_if.mem_beat_valid[0], bus_if.mem_busy[0]} !== 2'b00) begin
            n_fail++; $display("FAIL abort_drop: got %b expected 00", {bus_if.mem_beat_valid[0], bus_if.mem_busy[0]});
        end
        csr_read(8'h0C, d, v);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL abort_err: got %h expected 4", d); end
        csr_read(8'h04, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 0", d); end
        // Start and abort in one write: nothing launches
        csr_write(8'h00, 32'h21);
        n_checks++;
        if ({bus_if.mem_start[0], bus_if.mem_busy[0]} !== 2'b00) begin
            n_fail++; $display("FAIL start_abort: got %b expected 00", {bus_if.mem_start[0], bus_if.mem_busy[0]});
        end
    endtask

    task automatic test_reset_readback();
        logic [31:0] d; logic v;
        logic [9:0] obs;
        csr_write(8'h08, 32'h0000_0502);
        csr_write(8'h00, 32'h1);
        n_checks++;
        if (bus_if.mem_busy[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", bus_if.mem_busy[0]); end
        #2 rst_n = 1'b0;
        #1;
        obs = {bus_if.mem_start, bus_if.mem_beat_valid, bus_if.mem_beat_last, bus_if.mem_busy,
               bus_if.error_flag, bus_if.csr_rd_valid};
        n_checks++;
        if (obs !== 10'd0) begin n_fail++; $display("FAIL midrst_ctl: got %h expected 0", obs); end
        n_checks++;
        if ({bus_if.mem_mode, bus_if.csr_rd_data} !== 40'd0) begin
            n_fail++; $display("FAIL midrst_data: got %h expected 0", {bus_if.mem_mode, bus_if.csr_rd_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        csr_read(8'hF0, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'h1234_AB02}) begin n_fail++; $display("FAIL id_read: got %b/%h expected 1/1234ab02", v, d); end
        @(negedge clk);
        n_checks++;
        if ({bus_if.csr_rd_valid, bus_if.csr_rd_data} !== {1'b0, 32'h1234_AB02}) begin
            n_fail++; $display("FAIL id_hold: got %b/%h expected 0/1234ab02", bus_if.csr_rd_valid, bus_if.csr_rd_data);
        end
        csr_read(8'h20, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL unmapped: got %b/%h expected 1/0", v, d); end
        csr_read(8'h08, d, v);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cfg_after_reset: got %h expected 0", d); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_errors();
        test_abort();
        test_reset_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_seq.md
# mem_ctrl_seq

Parametrised, multi-channel successor to the single-channel CSR memory controller. Each of `NUM_CH` channels has its own CTRL/CFG/STATUS/ERROR registers behind one shared CSR port and a burst sequencer. The sequencer waits a programmed latency, then issues a programmed number of beats under a valid/ready handshake. The block sits between the CSR bus and the per-channel memory-side datapath.

## Interface
- `NUM_CH`, 2: number of channels, 1..8.
- `BLEN_W`, 8: burst-length field width (max burst = 2^BLEN_W − 1 beats).
- `LAT_W`, 4: latency field width.
- `ID_VALUE`, 32'h1234_AB02: value returned at the ID address.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `csr_wr_en`  in  1  write strobe, one cycle per write.
- `csr_rd_en`  in  1  read strobe.
- `csr_addr`  in  8  byte address.
- `csr_wr_data`  in  32  write data.
- `csr_rd_data`  out  32  read data, registered.
- `csr_rd_valid`  out  1  high one cycle after `csr_rd_en`.
- `mem_start`  out  NUM_CH  one-cycle pulse per channel at burst launch.
- `mem_mode`  out  4*NUM_CH  per-channel mode, from the latched CTRL[4:1].
- `mem_beat_valid`  out  NUM_CH  beat offered.
- `mem_beat_ready`  in  NUM_CH  beat accepted.
- `mem_beat_last`  out  NUM_CH  final beat of the burst.
- `mem_busy`  out  NUM_CH  channel state ≠ IDLE.
- `error_flag`  out  1  OR of all ERROR bits of all channels.

## Operation
- **Address map:** channel c base = c*0x10.
  - +0x0 CTRL: [0] start, self-clearing, reads 0; [4:1] mode; [5] abort, self-clearing.
  - +0x4 STATUS: [0] busy (RO); [1] done (sticky, W1C).
  - +0x8 CFG: [BLEN_W-1:0] burst length; [8+LAT_W-1:8] latency.
  - +0xC ERROR, all bits W1C: [0] zero-length start; [1] start while busy; [2] aborted.
  - 0xF0: ID (RO).
  - Unmapped reads return 0. Unmapped writes are ignored. Addresses at or above channel NUM_CH are unmapped.
- **Per-channel FSM:** IDLE → WAIT_LAT → BURST → DONE → IDLE.
  - **IDLE:** on a start write, CFG length and latency and CTRL mode are snapshotted.
    - Length 0: ERROR[0] is set and the FSM stays in IDLE.
    - Latency 0: go directly to BURST.
    - Otherwise: go to WAIT_LAT with the counter loaded with the latency.
  - **WAIT_LAT:** decrement each cycle; go to BURST when the count reaches 1.
  - **BURST:** `mem_beat_valid`=1. A beat is counted on valid&&ready. `mem_beat_last` is high while remaining==1. On the last acceptance, go to DONE.
  - **DONE:** one cycle; STATUS[1] is set; then return to IDLE.
- **mem_start** is high for the first cycle out of IDLE (WAIT_LAT or BURST).
- CFG and mode writes during busy update the register only. The running burst uses its snapshot.
- **Start while busy:** ignored; ERROR[1] is set.
- **Abort:** from any non-IDLE state, go to IDLE at the next edge. ERROR[2] is set, done is not set, and valid drops.
- **Start and abort in the same write:** abort wins; no burst launches.
- **Same-cycle read and write** to one address: the read returns the pre-write value.
- **Same-cycle W1C and hardware set** of a bit: set wins.

## Timing
- **Reset values:** all registers 0. Every output is 0 except `mem_mode`=0 and `csr_rd_data`=0.
- **Reset mid-burst:** outputs go to 0 asynchronously; the FSM returns to IDLE.
- **Start write** captured at edge T:
  - `mem_busy` and `mem_start` are high from T+1.
  - First `mem_beat_valid` at T+1+latency.
  - With ready held high, a burst of N beats ends with DONE at T+1+latency+N, and busy clears the cycle after.
- **Read latency:** 1 cycle; `csr_rd_data` holds its value until the next read.
- `error_flag` is registered: high one cycle after the ERROR bit is set.

## Structure
- **Package `mem_ctrl_seq_pkg`:** register offsets, channel stride, ID address, CTRL/STATUS/ERROR bit positions, and FSM state enum `seq_state_e`.
- **Sub-module `mem_burst_channel`:** FSM, counters, snapshot, and per-channel registers. Instantiated NUM_CH times via generate. The top level holds address decode, the read mux, and the error OR.

## Test plan
- **Basic burst:** CH0 CFG=0x0304 (len 4, lat 3), CTRL=0x3 → `mem_start` at T+1, valid from T+4, 4 beats with last on the 4th, STATUS reads 0x2, error_flag=0.
- **Backpressure:** CH1 len 3, lat 0, ready toggling 1,0,1,0,1 → exactly 3 accepted beats, last only on the 3rd, valid never drops mid-burst.
- **Error paths:**
  - Start with len 0 → ERROR=0x1 and no `mem_start`.
  - Start while busy → ERROR bit1 set and the burst is unaffected.
  - Write ERROR=0x3 → reads 0, error_flag falls.
- **Abort:** abort at beat 2 of an 8-beat burst → valid low next cycle, ERROR=0x4, STATUS done=0.
- **Reset and readback:** rst_n low mid-WAIT_LAT → all outputs 0 immediately. After release, reading 0xF0 returns 0x1234_AB02 with rd_valid one cycle later. Reading 0x20 with NUM_CH=2 returns 0.
